// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// between NUM_REQ producers. One grant per burst; a burst ends on req_last,
// after MAX_BURST beats, or after STALL_MAX consecutive idle cycles.
module afifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 8,
  localparam int GNT_W    = $clog2(NUM_REQ)
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic [15:0]               push_cnt
);

  localparam int unsigned NREQ_U       = NUM_REQ;
  localparam logic [7:0]  C_BEAT_LAST  = 8'(MAX_BURST - 1);
  localparam logic [7:0]  C_STALL_LAST = 8'(STALL_MAX - 1);
  localparam logic [GNT_W-1:0] C_PTR_RST = GNT_W'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           r_state;
  logic [GNT_W-1:0] r_grant_id;
  logic [GNT_W-1:0] r_rr_ptr;
  logic [7:0]       r_beat_cnt;
  logic [7:0]       r_stall_cnt;
  logic [15:0]      r_push_cnt;
  logic             r_busy;

  logic             w_ready;
  logic             w_gnt_valid;
  logic             w_gnt_last;
  logic             w_beat;
  logic [GNT_W-1:0] w_pick;
  logic             w_pick_found;

  function automatic logic [GNT_W-1:0] wrap_idx(input int unsigned base,
                                                input int unsigned off);
    return GNT_W'((base + off) % NREQ_U);
  endfunction

  // Ready is combinational so a beat costs no extra latency; reset masks it
  // so a beat presented in the reset cycle is never pushed.
  assign w_ready     = (r_state == ST_BURST) && !fifo_full && !wr_rst;
  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_gnt_last  = req_last[r_grant_id];
  assign w_beat      = w_ready && w_gnt_valid;

  // One-hot ready towards the granted requester only.
  always_comb begin
    req_ready = '0;
    req_ready[r_grant_id] = w_ready;
  end

  assign fifo_push    = w_beat;
  assign fifo_data_in = req_data[int'(r_grant_id)*DATA_W +: DATA_W];
  assign grant_id     = r_grant_id;
  assign busy         = r_busy;
  assign push_cnt     = r_push_cnt;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      if (!w_pick_found && req_valid[wrap_idx(32'(r_rr_ptr), k)]) begin
        w_pick       = wrap_idx(32'(r_rr_ptr), k);
        w_pick_found = 1'b1;
      end
    end
  end

  // Arbitration FSM, burst/stall counters and accepted-beat counter.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state     <= ST_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= C_PTR_RST;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
      r_push_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant_id <= w_pick;
            r_state    <= ST_BURST;
            r_busy     <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_beat) begin
            r_push_cnt  <= r_push_cnt + 16'd1;
            r_stall_cnt <= '0;
            if (w_gnt_last || (r_beat_cnt == C_BEAT_LAST)) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_rr_ptr   <= r_grant_id;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end else if (!w_gnt_valid) begin
            // Only a missing valid counts as a stall; full-flag waits do not.
            if (r_stall_cnt == C_STALL_LAST) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_rr_ptr    <= r_grant_id;
              r_beat_cnt  <= '0;
              r_stall_cnt <= '0;
            end else begin
              r_stall_cnt <= r_stall_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
